uart_fifo_periph: RTL and testbench
===================================

UART_FIFO_PERIPH -- requirements
Module: uart_fifo_periph

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, baud divisor register width.
REQ-004 SHALL have parameter DIV_RESET, default 814, divisor reset value (125 MHz / (16*9600)).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port valid  input  1  bus access request.
REQ-008 SHALL have port addr  input  3  word register index.
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port wstrb  input  1  1 = write, 0 = read.
REQ-011 SHALL have port rdata  output  32  registered read data.
REQ-012 SHALL have port ready  output  1  access-complete pulse.
REQ-013 SHALL have port irq  output  1  level interrupt.
REQ-014 SHALL have port rxd  input  1  serial in, asynchronous.
REQ-015 SHALL have port txd  output  1  serial out, idle high.

Function
REQ-016 SHALL register ready <= valid && !ready; side effects occur only when valid && !ready (accept cycle); rdata valid while ready=1.
REQ-017 SHALL map addr 0 DATA: write pushes wdata[7:0] to TX FIFO (dropped if full); read pops RX FIFO (returns 0, no pop, if empty).
REQ-018 SHALL map addr 1 STATUS read: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 overrun, bit5 frame_err, bit6 parity_err, bit7 tx_busy; write 1 to bits 4-6 clears them.
REQ-019 SHALL map addr 2 DIV (r/w, DIV_WIDTH bits); a write also clears the tick counter.
REQ-020 SHALL map addr 3 CTRL (r/w): bit0 rx_ie, bit1 tx_ie; addr 4-7 read 0, writes ignored.
REQ-021 SHALL generate 16x tick: counter counts 0..DIV then wraps; tick on count==DIV; period DIV+1 cycles; DIV=0 ticks every cycle.
REQ-022 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; 16 ticks per bit, LSB first, start=0, stop=1; IDLE pops FIFO when non-empty.
REQ-023 tx_busy SHALL be 1 in any TX state except IDLE.
REQ-024 RX SHALL pass rxd through a 2-flop synchroniser, detect falling edge in IDLE, recheck low at tick 8; if high return to IDLE (glitch rejected).
REQ-025 RX SHALL sample each data/parity/stop bit 16 ticks after the previous sample point.
REQ-026 Stop bit low SHALL set frame_err and discard byte; byte completing with RX FIFO full SHALL set overrun and discard byte.
REQ-027 FIFO push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-028 irq SHALL equal (rx_ie && !rx_empty) || (tx_ie && tx_empty && !tx_busy), registered.

Reset
REQ-029 Reset SHALL force txd=1, rdata=0, ready=0, irq=0, FIFOs empty, DIV=DIV_RESET, CTRL=0, sticky bits 0, both FSMs IDLE, tick counter 0.
REQ-030 Reset mid-frame SHALL abort; txd high from the reset assertion, partial RX byte discarded.

Configuration
REQ-031 With UART_PARITY_EN defined, SHALL send even parity in PARITY and check it on RX; mismatch sets parity_err and discards byte.
REQ-032 Without UART_PARITY_EN, PARITY state SHALL be skipped (8N1) and parity_err SHALL read 0.

Structure
REQ-033 Package uart_pkg SHALL hold register indices, STATUS bit positions, TX/RX state encodings.
REQ-034 FIFO SHALL be sub-module sync_fifo (WIDTH, DEPTH params, full/empty flags), instanced twice.

Verification
REQ-035 DIV=0, write DATA 0x55 -> txd low 16 cycles, then bits 1,0,1,0,1,0,1,0 each 16 cycles, then high; tx_busy=0 after stop.
REQ-036 TX_DEPTH=16, 17 DATA writes while DIV=814 -> first 16 transmitted in order, 17th dropped, tx_full=1 after write 16.
REQ-037 Drive rxd frame 0xA3 at DIV=0 -> rx_empty=0, DATA read returns 0x000000A3, irq=1 only when rx_ie=1.
REQ-038 RX FIFO full + one more frame -> overrun=1; write STATUS 0x10 -> overrun=0.
REQ-039 rxd 4-cycle low glitch at DIV=0 -> no byte received; stop bit low -> frame_err=1, FIFO unchanged.
REQ-040 Reset asserted mid TX byte -> txd=1, STATUS reads 0x00000006 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register indices, STATUS bit positions and FSM encodings for uart_fifo_periph
package uart_pkg;
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIV    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_OVERRUN    = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_TX_BUSY    = 7;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_fifo_periph_if.sv
// uart_fifo_periph_if: word-register bus with a one-cycle ready pulse per access
interface uart_fifo_periph_if;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic [31:0] rdata;
    logic        ready;
    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; simultaneous push and pop both take effect
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
    // Read/write pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
endmodule

// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: register-mapped UART with TX/RX FIFOs; define UART_PARITY_EN for even parity (8E1), default 8N1
module uart_fifo_periph
    import uart_pkg::*;
#(
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 814
) (
    input  logic              clk,
    input  logic              reset,
    uart_fifo_periph_if.slave bus,
    output logic              irq,
    input  logic              rxd,
    output logic              txd
);
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    logic accept, div_wr, tick, rx_ie, tx_ie, overrun, frame_err, parity_err;
    logic [DIV_WIDTH-1:0] div, cnt;
    logic [7:0] st_clr, status;
    logic [31:0] rd_val;
    logic tx_push, tx_pop, tx_full, tx_empty, tx_busy;
    logic [7:0] tx_dout;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    tx_state_t tx_state, tx_state_n;
    logic [3:0] tx_tcnt, tx_tcnt_n;
    logic [2:0] tx_bcnt, tx_bcnt_n;
    logic [7:0] tx_sh, tx_sh_n;
    logic tx_par, tx_par_n;
    rx_state_t rx_state, rx_state_n;
    logic [3:0] rx_tcnt, rx_tcnt_n;
    logic [2:0] rx_bcnt, rx_bcnt_n;
    logic [7:0] rx_sh, rx_sh_n;
    logic rx_par, rx_par_n, rx_s1, rx_s2, rx_prev;
    logic rx_ovr_set, rx_frm_set, rx_par_set;

    assign accept  = bus.valid && !bus.ready;
    assign div_wr  = accept && bus.wstrb && bus.addr == REG_DIV;
    assign st_clr  = (accept && bus.wstrb && bus.addr == REG_STATUS) ? bus.wdata[7:0] : 8'h00;
    assign tx_push = accept && bus.wstrb && bus.addr == REG_DATA;
    assign rx_pop  = accept && !bus.wstrb && bus.addr == REG_DATA;
    assign tick    = cnt == div;
    assign tx_busy = tx_state != TX_IDLE;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .din(bus.wdata[7:0]), .pop(tx_pop),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .din(rx_sh_n), .pop(rx_pop),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // STATUS assembly and read-data mux for the addressed register
    always_comb begin
        status = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_OVERRUN]    = overrun;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_PARITY_ERR] = parity_err;
        status[ST_TX_BUSY]    = tx_busy;
        rd_val = bus.addr == REG_DATA   ? (rx_empty ? 32'h0 : 32'(rx_dout)) :
                 bus.addr == REG_STATUS ? 32'(status) :
                 bus.addr == REG_DIV    ? 32'(div) :
                 bus.addr == REG_CTRL   ? {30'h0, tx_ie, rx_ie} : 32'h0;
    end

    // Bus handshake, registered read data, DIV and CTRL registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            div       <= DIV_WIDTH'(DIV_RESET);
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
        end else begin
            bus.ready <= accept;
            if (accept) bus.rdata <= bus.wstrb ? 32'h0 : rd_val;
            if (div_wr) div <= bus.wdata[DIV_WIDTH-1:0];
            if (accept && bus.wstrb && bus.addr == REG_CTRL) {tx_ie, rx_ie} <= bus.wdata[1:0];
        end
    end

    // Sticky error flags: a new error wins over a same-cycle software clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= rx_ovr_set || (overrun && !st_clr[ST_OVERRUN]);
            frame_err  <= rx_frm_set || (frame_err && !st_clr[ST_FRAME_ERR]);
            parity_err <= rx_par_set || (parity_err && !st_clr[ST_PARITY_ERR]);
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else irq <= (rx_ie && !rx_empty) || (tx_ie && tx_empty && !tx_busy);
    end

    // 16x oversampling tick: count 0..DIV, restart on a DIV write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= (div_wr || tick) ? '0 : cnt + DIV_WIDTH'(1);
    end

    // TX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
        end
    end

    // TX next state and line level; IDLE waits for a tick so the start bit is a full 16 ticks
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bcnt_n  = tx_bcnt;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        txd        = 1'b1;
        case (tx_state)
            TX_IDLE: if (tick && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_sh_n    = tx_dout;
                tx_par_n   = ^tx_dout;
                tx_tcnt_n  = '0;
                tx_state_n = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (tick) begin
                    tx_tcnt_n = tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        tx_bcnt_n  = '0;
                        tx_state_n = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                txd = tx_sh[0];
                if (tick) begin
                    tx_tcnt_n = tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        tx_sh_n   = tx_sh >> 1;
                        tx_bcnt_n = tx_bcnt + 3'd1;
                        if (tx_bcnt == 3'd7) tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tick) begin
                    tx_tcnt_n = tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: if (tick) begin
                tx_tcnt_n = tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // RX synchroniser, edge history and state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_sh    <= rx_sh_n;
            rx_par   <= rx_par_n;
        end
    end

    // RX next state: start bit rechecked at mid-bit, later samples every 16 ticks from there
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_sh_n    = rx_sh;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        rx_ovr_set = 1'b0;
        rx_frm_set = 1'b0;
        rx_par_set = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) begin
                rx_tcnt_n  = '0;
                rx_par_n   = 1'b0;
                rx_state_n = RX_START;
            end
            RX_START: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd7) begin
                    rx_tcnt_n  = '0;
                    rx_bcnt_n  = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15) begin
                    rx_sh_n   = {rx_s2, rx_sh[7:1]};
                    rx_par_n  = rx_par ^ rx_s2;
                    rx_bcnt_n = rx_bcnt + 3'd1;
                    if (rx_bcnt == 3'd7) rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15) begin
                    rx_par_n   = rx_par ^ rx_s2;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15) begin
                    rx_state_n = RX_IDLE;
                    if (!rx_s2) rx_frm_set = 1'b1;
                    else if (PAR_EN && rx_par) rx_par_set = 1'b1;
                    else if (rx_full) rx_ovr_set = 1'b1;
                    else rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb_uart_fifo_periph: scoreboard bench for uart_fifo_periph (TX frames decoded from txd, RX bytes read back over the bus)
module tb_uart_fifo_periph;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;
    logic irq, txd;
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart_fifo_periph_if bus();
    uart_fifo_periph dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq), .rxd(rxd), .txd(txd));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input bit w, input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.valid = 1'b1;
        bus.wstrb = w;
        bus.addr  = a;
        bus.wdata = wd;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) break;
        end
        chk("bus_ready", 32'(bus.ready), 1);
        rd = bus.rdata;
        bus.valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(1'b1, a, d, r);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] r);
        bus_xfer(1'b0, a, 32'h0, r);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(1'b0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic data_wr(input logic [7:0] b);
        wr(REG_DATA, 32'(b));
        tx_exp.push_back(b);
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] e;
        e = rx_exp.size() != 0 ? rx_exp.pop_front() : 8'h00;
        rd_chk(tag, REG_DATA, 32'(e));
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame at DIV=0 (16 cycles per bit); model stores good bytes while the FIFO has room
    task automatic send_rx(input logic [7:0] b, input bit good_stop);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b[i], 16);
`ifdef UART_PARITY_EN
        hold(^b, 16);
`endif
        hold(good_stop, 16);
        hold(1'b1, 20);
        if (good_stop && rx_exp.size() < 16) rx_exp.push_back(b);
    endtask

    // TX monitor: decode frames on txd at mid-bit (DIV=0) and compare against the scoreboard
    initial begin : tx_mon
        logic [7:0] b;
        logic s0, sp;
        forever begin
            @(negedge txd);
            if (mon_en) begin
                repeat (8) @(posedge clk);
                #1;
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
`ifdef UART_PARITY_EN
                repeat (16) @(posedge clk);
                #1;
                chk("tx_parity", 32'(txd), 32'(^b));
`endif
                repeat (16) @(posedge clk);
                #1;
                sp = txd;
                chk("tx_start_bit", 32'(s0), 0);
                chk("tx_stop_bit", 32'(sp), 1);
                chk("tx_frame_expected", 32'(tx_exp.size() != 0), 1);
                if (tx_exp.size() != 0) chk("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0] pat;
        int t, low;
        bus.valid = 1'b0;
        bus.wstrb = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd), 1);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rdata", bus.rdata, 0);
        reset = 1'b0;
        rd_chk("rst_status", REG_STATUS, 32'h6);
        rd_chk("rst_div", REG_DIV, 32'd814);
        rd_chk("rst_ctrl", REG_CTRL, 0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("unmapped_read", 3'd6, 0);
        rd_chk("rx_empty_data_read", REG_DATA, 0);

        // Exact TX waveform for 0x55 at DIV=0
        wr(REG_DIV, 0);
        rd_chk("div_write", REG_DIV, 0);
        mon_en = 1'b1;
        data_wr(8'h55);
        t = 0;
        while (txd && t < 50) begin
            t++;
            @(posedge clk);
            #1;
        end
        low = 0;
        while (!txd && low < 100) begin
            low++;
            @(posedge clk);
            #1;
        end
        chk("tx55_start_cycles", 32'(low), 16);
        pat = 8'h55;
        repeat (7) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("tx55_data_bit", 32'(txd), 32'(pat[i]));
            repeat (16) @(posedge clk);
            #1;
        end
`ifdef UART_PARITY_EN
        chk("tx55_parity_bit", 32'(txd), 0);
        repeat (16) @(posedge clk);
        #1;
`endif
        chk("tx55_stop_bit", 32'(txd), 1);
        repeat (20) @(posedge clk);
        rd(REG_STATUS, r);
        chk("tx55_idle_status", r & 32'h83, 32'h02);

        // 17 writes while the divisor is slow: 16 queued, 17th dropped
        wr(REG_DIV, 814);
        for (int i = 0; i < 16; i++) data_wr(8'(8'h10 + i * 7));
        rd(REG_STATUS, r);
        chk("tx_full_after_16", 32'(r[ST_TX_FULL]), 1);
        chk("tx_busy_before_tick", 32'(r[ST_TX_BUSY]), 0);
        wr(REG_DATA, 32'hEE);
        rd(REG_STATUS, r);
        chk("tx_full_after_17", 32'(r[ST_TX_FULL]), 1);
        wr(REG_DIV, 0);
        t = 0;
        while (tx_exp.size() != 0 && t < 4000) begin
            t++;
            @(posedge clk);
        end
        repeat (300) @(posedge clk);
        chk("tx_queue_drained", 32'(tx_exp.size()), 0);
        rd(REG_STATUS, r);
        chk("tx_drained_status", r & 32'h83, 32'h02);
        wr(REG_CTRL, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_tx_ie", 32'(irq), 1);
        wr(REG_CTRL, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_tx_ie_off", 32'(irq), 0);

        // RX 0xA3 with interrupt gating
        send_rx(8'hA3, 1'b1);
        rd(REG_STATUS, r);
        chk("rx_not_empty", 32'(r[ST_RX_EMPTY]), 0);
        chk("irq_rx_ie0", 32'(irq), 0);
        wr(REG_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_rx_ie1", 32'(irq), 1);
        rx_read("rx_a3");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_rx_drained", 32'(irq), 0);
        wr(REG_CTRL, 0);

        // Glitch rejection and framing error
        hold(1'b0, 4);
        hold(1'b1, 200);
        rd(REG_STATUS, r);
        chk("glitch_rx_empty", 32'(r[ST_RX_EMPTY]), 1);
        chk("glitch_no_frame_err", 32'(r[ST_FRAME_ERR]), 0);
        send_rx(8'h3C, 1'b0);
        rd(REG_STATUS, r);
        chk("frame_err_set", 32'(r[ST_FRAME_ERR]), 1);
        chk("frame_err_rx_empty", 32'(r[ST_RX_EMPTY]), 1);
        chk("parity_err_clear", 32'(r[ST_PARITY_ERR]), 0);
        wr(REG_STATUS, 32'h20);
        rd(REG_STATUS, r);
        chk("frame_err_cleared", 32'(r[ST_FRAME_ERR]), 0);

        // Fill the RX FIFO, overflow once, clear overrun, then drain in order
        for (int i = 0; i < 16; i++) send_rx(8'(8'hC1 + i * 3), 1'b1);
        rd(REG_STATUS, r);
        chk("rx_full", 32'(r[ST_RX_FULL]), 1);
        chk("overrun_not_yet", 32'(r[ST_OVERRUN]), 0);
        send_rx(8'h99, 1'b1);
        rd(REG_STATUS, r);
        chk("overrun_set", 32'(r[ST_OVERRUN]), 1);
        wr(REG_STATUS, 32'h10);
        rd(REG_STATUS, r);
        chk("overrun_cleared", 32'(r[ST_OVERRUN]), 0);
        chk("rx_still_full", 32'(r[ST_RX_FULL]), 1);
        for (int i = 0; i < 16; i++) rx_read("rx_fifo_order");
        rd(REG_STATUS, r);
        chk("rx_drained_empty", 32'(r[ST_RX_EMPTY]), 1);
        chk("rx_queue_drained", 32'(rx_exp.size()), 0);

        // Reset in the middle of a TX byte
        mon_en = 1'b0;
        wr(REG_CTRL, 32'h3);
        wr(REG_DATA, 32'hF0);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_frame_txd_low", 32'(txd), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_txd_high", 32'(txd), 1);
        chk("reset_irq_low", 32'(irq), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rd_chk("post_reset_status", REG_STATUS, 32'h6);
        rd_chk("post_reset_div", REG_DIV, 32'd814);
        rd_chk("post_reset_ctrl", REG_CTRL, 0);
        repeat (300) @(posedge clk);
        #1;
        chk("post_reset_txd_idle", 32'(txd), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
